regfile_mpw_clr: RTL and testbench

// - Parametrised multi-write, multi-read register file: NR_WR write ports, NR_RD async read ports, range LO..HI.
// - Hardware clear engine re-initialises every entry after reset or on CLR request; BUSY flags it.
// - Sticky error flag for out-of-range writes. Drop-in storage for BSV-generated pipelines needing >1 write/cycle.

---
 rtl/regfile_mpw_clr.sv | 163 ++++++++++++++++
 tb/tb_regfile_mpw_clr.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mpw_clr.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mpw_clr
//  Description : Multi-write / multi-read register file (index range LO..HI)
//                with a hardware clear engine. A sticky flag records
//                out-of-range writes.
//                Optional macro REGFILE_BYPASS_EN forwards same-cycle write
//                data to matching reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mpw_clr #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LO         = 0,
    parameter int                    HI         = 31,
    parameter int                    NR_RD      = 2,
    parameter int                    NR_WR      = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          CLR,
    input  logic [NR_WR-1:0]              WE,
    input  logic [NR_WR*ADDR_WIDTH-1:0]   ADDR_IN,
    input  logic [NR_WR*DATA_WIDTH-1:0]   D_IN,
    input  logic [NR_RD*ADDR_WIDTH-1:0]   ADDR_RD,
    output logic [NR_RD*DATA_WIDTH-1:0]   D_OUT,
    output logic                          BUSY,
    output logic                          WR_ERR
);

    localparam logic [ADDR_WIDTH-1:0] C_LO_ADDR = ADDR_WIDTH'(LO);
    localparam logic [ADDR_WIDTH-1:0] C_HI_ADDR = ADDR_WIDTH'(HI);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt;
    logic [ADDR_WIDTH-1:0]   w_cnt_nxt;
    logic                    r_wr_err;
    logic                    w_wr_err_nxt;

    logic [DATA_WIDTH-1:0]   r_arr [LO:HI];

    logic [ADDR_WIDTH-1:0]   w_waddr    [NR_WR];
    logic [DATA_WIDTH-1:0]   w_wdata    [NR_WR];
    logic [NR_WR-1:0]        w_wr_in_rng;
    logic [NR_WR-1:0]        w_wr_bad;
    logic [ADDR_WIDTH-1:0]   w_raddr    [NR_RD];
    logic [DATA_WIDTH-1:0]   w_rdata    [NR_RD];

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (int'(a) >= LO) && (int'(a) <= HI);
    endfunction

    // ------------------------------------------------------------------------
    // Write port unpacking and range check
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NR_WR; k++) begin : g_wr
            assign w_waddr[k]     = ADDR_IN[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata[k]     = D_IN[k*DATA_WIDTH +: DATA_WIDTH];
            assign w_wr_in_rng[k] = f_in_range(w_waddr[k]);
            assign w_wr_bad[k]    = WE[k] & ~w_wr_in_rng[k];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Control FSM: CLR behaves exactly like a reset except for the RST port
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_CLEAR;
            r_cnt    <= C_LO_ADDR;
            r_wr_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wr_err <= w_wr_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wr_err_nxt = r_wr_err;
        if (CLR) begin
            w_state_nxt  = S_CLEAR;
            w_cnt_nxt    = C_LO_ADDR;
            w_wr_err_nxt = 1'b0;
        end else if (r_state == S_CLEAR) begin
            if (r_cnt == C_HI_ADDR) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else if (|w_wr_bad) begin
            w_wr_err_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: the clear engine owns the array while clearing; in IDLE the
    // later port assignment overrides earlier ones to the same entry.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST && !CLR) begin
            for (int e = LO; e <= HI; e++) begin
                if (r_state == S_CLEAR) begin
                    if (int'(r_cnt) == e) begin
                        r_arr[e] <= INIT_VALUE;
                    end
                end else begin
                    for (int k = 0; k < NR_WR; k++) begin
                        if (WE[k] && (int'(w_waddr[k]) == e)) begin
                            r_arr[e] <= w_wdata[k];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Asynchronous read ports
    // ------------------------------------------------------------------------
    generate
        for (genvar j = 0; j < NR_RD; j++) begin : g_rd
            assign w_raddr[j] = ADDR_RD[j*ADDR_WIDTH +: ADDR_WIDTH];

            always_comb begin
                w_rdata[j] = INIT_VALUE;
                if (r_state == S_IDLE) begin
                    for (int e = LO; e <= HI; e++) begin
                        if (int'(w_raddr[j]) == e) begin
                            w_rdata[j] = r_arr[e];
                        end
                    end
`ifdef REGFILE_BYPASS_EN
                    if (!RST && !CLR) begin
                        for (int k = 0; k < NR_WR; k++) begin
                            if (WE[k] && w_wr_in_rng[k] && (w_waddr[k] == w_raddr[j])) begin
                                w_rdata[j] = w_wdata[k];
                            end
                        end
                    end
`endif
                end
            end

            assign D_OUT[j*DATA_WIDTH +: DATA_WIDTH] = w_rdata[j];
        end
    endgenerate

    assign BUSY   = (r_state == S_CLEAR);
    assign WR_ERR = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mpw_clr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mpw_clr
//  Description : Randomised bench for regfile_mpw_clr; a default instance and
//                a widened instance (AW=6, LO=2, HI=40, nonzero init) share
//                stimulus and are compared against an array-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mpw_clr;

    localparam int          LO_A   = 0;
    localparam int          HI_A   = 31;
    localparam int          LO_B   = 2;
    localparam int          HI_B   = 40;
    localparam logic [31:0] INIT_A = 32'h0000_0000;
    localparam logic [31:0] INIT_B = 32'hC0DE_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [1:0]  we;
    logic [5:0]  wa [2];
    logic [31:0] wd [2];
    logic [5:0]  ra [2];

    logic [63:0] dout_a, dout_b;
    logic        busy_a, busy_b, err_a, err_b;

    always #5 clk = ~clk;

    regfile_mpw_clr u_dut_a (
        .CLK     (clk),
        .RST     (rst),
        .CLR     (clr),
        .WE      (we),
        .ADDR_IN ({wa[1][4:0], wa[0][4:0]}),
        .D_IN    ({wd[1], wd[0]}),
        .ADDR_RD ({ra[1][4:0], ra[0][4:0]}),
        .D_OUT   (dout_a),
        .BUSY    (busy_a),
        .WR_ERR  (err_a)
    );

    regfile_mpw_clr #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .LO         (LO_B),
        .HI         (HI_B),
        .NR_RD      (2),
        .NR_WR      (2),
        .INIT_VALUE (INIT_B)
    ) u_dut_b (
        .CLK     (clk),
        .RST     (rst),
        .CLR     (clr),
        .WE      (we),
        .ADDR_IN ({wa[1], wa[0]}),
        .D_IN    ({wd[1], wd[0]}),
        .ADDR_RD ({ra[1], ra[0]}),
        .D_OUT   (dout_b),
        .BUSY    (busy_b),
        .WR_ERR  (err_b)
    );

    // Reference model: contents, remaining clear cycles and error flag
    logic [31:0] mem [2][64];
    int          busy_left [2];
    logic        err_m [2];
    bit          model_ok = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic int lo_of(int i);   return (i == 0) ? LO_A : LO_B; endfunction
    function automatic int hi_of(int i);   return (i == 0) ? HI_A : HI_B; endfunction
    function automatic int mask_of(int i); return (i == 0) ? 31 : 63;     endfunction
    function automatic logic [31:0] init_of(int i); return (i == 0) ? INIT_A : INIT_B; endfunction

    function automatic bit in_rng(int i, int a);
        return (a >= lo_of(i)) && (a <= hi_of(i));
    endfunction

    function automatic logic [31:0] exp_rd(int i, logic [5:0] raddr);
        int          a;
        logic [31:0] r;
        a = int'(raddr) & mask_of(i);
        if (busy_left[i] > 0) return init_of(i);
        r = in_rng(i, a) ? mem[i][a] : init_of(i);
`ifdef REGFILE_BYPASS_EN
        if (!rst && !clr) begin
            for (int k = 0; k < 2; k++) begin
                int wa_k;
                wa_k = int'(wa[k]) & mask_of(i);
                if (we[k] && in_rng(i, wa_k) && wa_k == a) r = wd[k];
            end
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_checks();
        for (int i = 0; i < 2; i++) begin
            logic        busy_o, err_o;
            logic [63:0] d_o;
            busy_o = (i == 0) ? busy_a : busy_b;
            err_o  = (i == 0) ? err_a  : err_b;
            d_o    = (i == 0) ? dout_a : dout_b;
            check($sformatf("busy%0d", i),   32'(busy_o), 32'(busy_left[i] > 0));
            check($sformatf("wr_err%0d", i), 32'(err_o),  32'(err_m[i]));
            for (int j = 0; j < 2; j++) begin
                check($sformatf("rd%0d_port%0d_addr%0d", i, j, ra[j]),
                      d_o[j*32 +: 32], exp_rd(i, ra[j]));
            end
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < 2; i++) begin
            if (rst || clr) begin
                busy_left[i] = hi_of(i) - lo_of(i) + 1;
                err_m[i]     = 1'b0;
                for (int a = 0; a < 64; a++) mem[i][a] = init_of(i);
            end else if (busy_left[i] > 0) begin
                busy_left[i]--;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (we[k]) begin
                        int a;
                        a = int'(wa[k]) & mask_of(i);
                        if (in_rng(i, a)) mem[i][a] = wd[k];
                        else              err_m[i]  = 1'b1;
                    end
                end
            end
        end
    endtask

    // Called at a falling edge with inputs already driven
    task automatic step();
        #1;
        if (model_ok) do_checks();
        @(posedge clk);
        update_model();
        model_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        we = 2'($urandom);
        for (int k = 0; k < 2; k++) begin
            wa[k] = 6'($urandom_range(0, 47));
            wd[k] = $urandom;
        end
        if ($urandom_range(0, 4) == 0) wa[1] = wa[0];
        for (int j = 0; j < 2; j++) begin
            if ($urandom_range(0, 2) == 0) ra[j] = wa[$urandom_range(0, 1)];
            else                           ra[j] = 6'($urandom_range(0, 63));
        end
        rst = ($urandom_range(0, 399) == 0);
        clr = ($urandom_range(0, 149) == 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = '0;
        for (int k = 0; k < 2; k++) begin
            wa[k] = '0; wd[k] = '0; ra[k] = '0;
        end
        @(negedge clk);
        step();

        // Writes issued while clearing must be dropped
        repeat (28) begin rand_inputs(); rst = 1'b0; clr = 1'b0; step(); end
        we = '0;
        repeat (14) step();

        // Every address reads the init value after the clear
        for (int a = 0; a < 64; a += 2) begin
            ra[0] = 6'(a); ra[1] = 6'(a + 1);
            step();
        end

        // Two ports writing one address: port 1 wins
        we = 2'b11; wa[0] = 6'd3; wa[1] = 6'd3;
        wd[0] = 32'hAAAA_0000; wd[1] = 32'h5555_1111;
        ra[0] = 6'd3; ra[1] = 6'd4;
        step();
        we = '0; ra[1] = 6'd3;
        step();

        // Out-of-range write on the widened instance, then read it back
        we = 2'b01; wa[0] = 6'd50; wd[0] = 32'h1234_5678;
        step();
        we = '0; ra[0] = 6'd50; ra[1] = 6'd1;
        repeat (3) step();

        // CLR in the middle of a clear sequence restarts it
        rst = 1'b1; step(); rst = 1'b0;
        repeat (9) begin rand_inputs(); rst = 1'b0; clr = 1'b0; step(); end
        clr = 1'b1; step(); clr = 1'b0;
        repeat (45) begin rand_inputs(); rst = 1'b0; clr = 1'b0; step(); end

        repeat (800) begin rand_inputs(); step(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
